// File: rtl/cfg_mem_pkg.sv
// ============================================================================
// Module : cfg_mem_pkg
// Brief  : Shared constants, readback state encoding and frame-count helper
//          for the tile configuration memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cfg_mem_pkg;

    localparam int ERR_MULTI_STROBE      = 0;
    localparam int ERR_COMMIT_INCOMPLETE = 1;

    typedef enum logic [0:0] {
        RB_IDLE = 1'b0,
        RB_BUSY = 1'b1
    } rb_state_t;

    function automatic int cfg_num_frames(input int config_bits, input int frame_bits);
        return (config_bits + frame_bits - 1) / frame_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_frame_reg.sv
// ============================================================================
// Module : cfg_frame_reg
// Brief  : One frame's shadow/active register pair; shadow loads on i_wr_en,
//          active takes the (pre-write) shadow on i_commit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cfg_frame_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_active
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow <= i_data;
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_active = r_active;

endmodule

`default_nettype wire

// File: rtl/cfg_frame_mem_ctrl.sv
// ============================================================================
// Module : cfg_frame_mem_ctrl
// Brief  : Double-buffered tile configuration memory with strobe-edge frame
//          capture, atomic commit, sticky protocol errors and optional
//          readback (enabled by macro CFG_READBACK_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cfg_frame_mem_ctrl
    import cfg_mem_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 64
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic [FrameBitsPerRow-1:0]         FrameData,
    input  logic [MaxFramesPerCol-1:0]         FrameStrobe,
    input  logic                               Commit,
    input  logic                               ErrClr,
    output logic [NoConfigBits-1:0]            ConfigBits,
    output logic                               ConfigValid,
    output logic [1:0]                         Error,
    input  logic                               ReadbackReq,
    input  logic [$clog2(MaxFramesPerCol)-1:0] ReadbackSel,
    output logic [FrameBitsPerRow-1:0]         ReadbackData,
    output logic                               ReadbackValid
);

    localparam int c_NO_FRAMES = cfg_num_frames(NoConfigBits, FrameBitsPerRow);
    localparam int c_SEL_W     = $clog2(MaxFramesPerCol);
    localparam int c_FLAT_W    = c_NO_FRAMES * FrameBitsPerRow;

    if (c_NO_FRAMES > MaxFramesPerCol) begin : g_bad_cfg
        $error("cfg_frame_mem_ctrl: NoConfigBits needs more frames than MaxFramesPerCol");
    end

    logic [c_NO_FRAMES-1:0]     r_prev;
    logic [c_NO_FRAMES-1:0]     r_loaded;
    logic [1:0]                 r_error;
    logic                       r_cfg_valid;

    logic [c_NO_FRAMES-1:0]     w_edge;
    logic [c_NO_FRAMES-1:0]     w_wr_en;
    logic                       w_multi_edge;
    logic                       w_one_edge;
    logic                       w_all_loaded;
    logic                       w_commit_ok;
    logic                       w_commit_bad;
    logic [1:0]                 w_err_set;
    logic [FrameBitsPerRow-1:0] w_active [c_NO_FRAMES];
    logic [c_FLAT_W-1:0]        w_flat;

    // x & (x-1) is non-zero exactly when two or more edges fire together
    assign w_edge       = FrameStrobe[c_NO_FRAMES-1:0] & ~r_prev;
    assign w_multi_edge = (w_edge & (w_edge - c_NO_FRAMES'(1))) != '0;
    assign w_one_edge   = (w_edge != '0) && !w_multi_edge;
    assign w_wr_en      = w_one_edge ? w_edge : '0;
    assign w_all_loaded = &r_loaded;
    assign w_commit_ok  = Commit && w_all_loaded;
    assign w_commit_bad = Commit && !w_all_loaded;

    always_comb begin
        w_err_set                        = 2'b00;
        w_err_set[ERR_MULTI_STROBE]      = w_multi_edge;
        w_err_set[ERR_COMMIT_INCOMPLETE] = w_commit_bad;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_prev      <= '1;
            r_loaded    <= '0;
            r_error     <= 2'b00;
            r_cfg_valid <= 1'b0;
        end else begin
            r_prev   <= FrameStrobe[c_NO_FRAMES-1:0];
            r_loaded <= (w_commit_ok ? '0 : r_loaded) | w_wr_en;
            r_error  <= (ErrClr ? 2'b00 : r_error) | w_err_set;
            if (w_commit_ok) begin
                r_cfg_valid <= 1'b1;
            end
        end
    end

    for (genvar f = 0; f < c_NO_FRAMES; f++) begin : g_frame
        cfg_frame_reg #(
            .WIDTH (FrameBitsPerRow)
        ) u_frame (
            .clk      (CLK),
            .rst      (Reset),
            .i_wr_en  (w_wr_en[f]),
            .i_commit (w_commit_ok),
            .i_data   (FrameData),
            .o_active (w_active[f])
        );
        assign w_flat[f*FrameBitsPerRow +: FrameBitsPerRow] = w_active[f];
    end

    assign ConfigBits  = w_flat[NoConfigBits-1:0];
    assign ConfigValid = r_cfg_valid;
    assign Error       = r_error;

    if (c_FLAT_W > NoConfigBits) begin : g_flat_unused
        logic w_unused_flat;
        assign w_unused_flat = ^w_flat[c_FLAT_W-1:NoConfigBits];
    end

    if (c_NO_FRAMES < MaxFramesPerCol) begin : g_strobe_unused
        logic w_unused_strobe;
        assign w_unused_strobe = ^FrameStrobe[MaxFramesPerCol-1:c_NO_FRAMES];
    end

`ifdef CFG_READBACK_EN
    rb_state_t                  r_rb_state;
    logic [c_SEL_W-1:0]         r_rb_sel;
    logic [FrameBitsPerRow-1:0] r_rb_data;
    logic                       r_rb_valid;
    logic [FrameBitsPerRow-1:0] w_rb_mux;

    // Selections beyond the implemented frames fall through to zero
    always_comb begin
        w_rb_mux = '0;
        for (int k = 0; k < c_NO_FRAMES; k++) begin
            if (r_rb_sel == c_SEL_W'(k)) begin
                w_rb_mux = w_active[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_rb_state <= RB_IDLE;
            r_rb_sel   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            case (r_rb_state)
                RB_IDLE: begin
                    r_rb_valid <= 1'b0;
                    if (ReadbackReq) begin
                        r_rb_sel   <= ReadbackSel;
                        r_rb_state <= RB_BUSY;
                    end
                end
                RB_BUSY: begin
                    r_rb_data  <= w_rb_mux;
                    r_rb_valid <= 1'b1;
                    r_rb_state <= RB_IDLE;
                end
                default: begin
                    r_rb_valid <= 1'b0;
                    r_rb_state <= RB_IDLE;
                end
            endcase
        end
    end

    assign ReadbackData  = r_rb_data;
    assign ReadbackValid = r_rb_valid;
`else
    logic w_unused_rb;
    assign w_unused_rb   = ReadbackReq ^ (^ReadbackSel);
    assign ReadbackData  = '0;
    assign ReadbackValid = 1'b0;
`endif

endmodule

`default_nettype wire
